// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver that samples the line at 16x the baud rate.
// It rejects start-bit glitches and flags framing errors.
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high
//   rx         serial line; idle high; asynchronous to clk
//   rx_data    last correctly framed byte; held until the next good frame
//   rx_done    one-clk pulse when rx_data has been updated
//   rx_busy    high in every FSM state except IDLE
//   frame_err  one-clk pulse when the stop bit is sampled low
module uart_rx #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int TICK_DIV   = CLK_FREQ / (BAUD * OVERSAMPLE)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       rx_busy,
  output logic       frame_err
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] STOP      = 3'd3;
  localparam logic [2:0] WAIT_HIGH = 3'd4;

  // Synchronizer flops reset to the idle level, so reset never looks like a start bit.
  logic rx_m, rx_s;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // Free-running sample tick. It is deliberately not realigned to the start edge.
  // The up-to-one-tick phase error is absorbed by sampling at mid-bit.
  logic [TW-1:0] t_cnt;
  logic          tick;
  assign tick = (t_cnt == TW'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     t_cnt <= '0;
    else if (tick) t_cnt <= '0;
    else           t_cnt <= t_cnt + 1'b1;
  end

  logic [2:0] state;
  logic [3:0] s_cnt;
  logic [2:0] b_cnt;
  logic [7:0] shreg;

  assign rx_busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      s_cnt     <= '0;
      b_cnt     <= '0;
      shreg     <= '0;
      rx_data   <= 8'h00;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      if (tick) begin
        case (state)
          IDLE: begin
            if (!rx_s) begin
              state <= START;
              s_cnt <= '0;
            end
          end
          START: begin
            // Re-check the line at mid start bit. A high here means the low was a glitch.
            if (s_cnt == 4'd7) begin
              s_cnt <= '0;
              b_cnt <= '0;
              state <= rx_s ? IDLE : DATA;
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
          DATA: begin
            if (s_cnt == 4'd15) begin
              s_cnt <= '0;
              shreg <= {rx_s, shreg[7:1]};
              if (b_cnt == 3'd7) state <= STOP;
              else               b_cnt <= b_cnt + 1'b1;
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
          STOP: begin
            // Leaving at mid stop bit leaves half a bit of margin for a back-to-back start edge.
            if (s_cnt == 4'd15) begin
              s_cnt <= '0;
              if (rx_s) begin
                rx_data <= shreg;
                rx_done <= 1'b1;
                state   <= IDLE;
              end else begin
                frame_err <= 1'b1;
                state     <= WAIT_HIGH;
              end
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
          WAIT_HIGH: begin
            // A held-low line (break) must not retrigger reception.
            if (rx_s) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
